mig7_traffic_gen: RTL and testbench
===================================

// Module: mig7_traffic_gen
// PURPOSE
//   Parametrised DDR3 traffic generator/checker driving the MIG7 user interface; next generation of mig7_stub.
//   Writes a deterministic pattern over NBEATS consecutive beats, reads them back and compares against the expected data.
//   Runs in write+read, write-only or read-only mode; reports mismatches.
//   Sits on ui_clk between the MIG7 controller and board control/status logic.
// PARAMETERS
//   DWIDTH     128            app data width, multiple of 32; mask width = DWIDTH/8
//   AWIDTH     28             app_addr width
//   BASE_ADDR  0              first beat address
//   ADDR_STEP  8              address increment per beat (one BL8 burst)
//   NBEATS     1024           beats per pass, >=1, <=2^32
//   MAX_OUTST  32             max read commands issued but not yet returned
//   SEED       32'hA5C3_1E0F  pattern seed
// PORTS
//   clk                  in   1          ui_clk
//   rst                  in   1          async reset, active-high
//   start                in   1          one-cycle request to run a pass
//   mode                 in   2          00 wr+rd, 01 wr only, 10 rd only, 11 = 00
//   busy                 out  1          pass in progress
//   done                 out  1          pass finished; held until next accepted start
//   error                out  1          sticky: any mismatch in the last pass
//   err_count            out  16         mismatching beats, saturates at 16'hFFFF
//   app_addr             out  AWIDTH     MIG command address
//   app_cmd              out  3          000 write, 001 read
//   app_en               out  1          command valid
//   app_wdf_data         out  DWIDTH     write data
//   app_wdf_end          out  1          equals app_wdf_wren
//   app_wdf_mask         out  DWIDTH/8   constant 0
//   app_wdf_wren         out  1          write data valid
//   app_rd_data          in   DWIDTH     read data
//   app_rd_data_end      in   1          ignored
//   app_rd_data_valid    in   1          read data valid
//   app_rdy              in   1          command accepted when app_en & app_rdy
//   app_wdf_rdy          in   1          data accepted when app_wdf_wren & app_wdf_rdy
//   app_sr_req, app_ref_req, app_zq_req   out 1 each   constant 0
//   app_sr_active, app_ref_ack, app_zq_ack in 1 each   ignored
//   init_calib_complete  in   1          MIG calibration done
// BEHAVIOUR
//   Reset: all outputs 0, FSM in IDLE. Reset mid-pass aborts immediately. No recovery of in-flight MIG reads.
//   Pattern: P(k) is the beat-k data; its 32-bit lane j = SEED ^ k[31:0] ^ j. Address(k) = BASE_ADDR + k*ADDR_STEP mod 2^AWIDTH.
//   FSM: IDLE -> WAIT_CAL -> WR -> RD -> DONE; mode 01 skips RD, mode 10 skips WR.
//   - IDLE: start=1 latches mode and clears done, error and err_count. Next cycle busy=1, WAIT_CAL. start is ignored when busy.
//   - WAIT_CAL: stay while init_calib_complete=0.
//   - WR: command and data channels are tracked independently.
//     Each channel holds its value until its handshake completes, then advances to beat k+1.
//     The first app_en/app_wdf_wren is asserted the cycle after entry.
//     Leave WR once both channels have completed NBEATS handshakes.
//   - RD: issue NBEATS read commands, at most MAX_OUTST outstanding.
//     A command returning and a new command issuing in the same cycle leaves the outstanding count unchanged.
//     Each app_rd_data_valid beat is compared with P(r), r = receive index (in order).
//     A mismatch increments err_count (saturating) and sets error.
//     Leave RD once NBEATS beats have been received.
//   - DONE: busy=0, done=1, return to IDLE in the same cycle.
//   - init_calib_complete falling in WR/RD: issue no new command/data, keep any asserted app_en/app_wdf_wren held, resume on rise.
//   - NBEATS=1 and k wrap-around are legal. Address wraps silently modulo 2^AWIDTH.
//   - Latency: IDLE->first app_en is 2 cycles with calibration done.
// TESTING
//   1 MIG model always ready, NBEATS=4, mode 00 -> 4 writes at addr 0,8,16,24, data lane0 = SEED^k; 4 reads; done=1, err_count=0.
//   2 app_rdy/app_wdf_rdy toggled randomly -> app_addr/app_wdf_data held stable while not accepted; no beat lost or duplicated.
//   3 Model corrupts read beat 2 -> error=1, err_count=1; start again with no corruption -> error=0.
//   4 Read latency 100 cycles, MAX_OUTST=4 -> outstanding never exceeds 4; all NBEATS beats checked.
//   5 mode 10 after a mode 01 pass -> no writes issued, err_count=0; mode 10 on an unwritten model -> err_count=NBEATS.
//   6 rst asserted during RD -> outputs 0 asynchronously; start during busy -> ignored; calib drop mid-WR -> held app_en kept.

Source files
------------

// File: rtl/mig7_traffic_gen.sv
// mig7_traffic_gen: DDR3 traffic generator/checker on the MIG7 user interface.
// Writes a seed-derived pattern over NBEATS consecutive beats, reads the beats
// back in order and counts the ones that differ from the expected pattern.
module mig7_traffic_gen #(
  parameter int unsigned     DWIDTH    = 128,
  parameter int unsigned     AWIDTH    = 28,
  parameter longint unsigned BASE_ADDR = 0,
  parameter longint unsigned ADDR_STEP = 8,
  parameter longint unsigned NBEATS    = 1024,
  parameter int unsigned     MAX_OUTST = 32,
  parameter logic [31:0]     SEED      = 32'hA5C3_1E0F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         err_count,
  output logic [AWIDTH-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DWIDTH-1:0]   app_wdf_data,
  output logic                app_wdf_end,
  output logic [DWIDTH/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  input  logic [DWIDTH-1:0]   app_rd_data,
  input  logic                app_rd_data_end,
  input  logic                app_rd_data_valid,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  output logic                app_sr_req,
  output logic                app_ref_req,
  output logic                app_zq_req,
  input  logic                app_sr_active,
  input  logic                app_ref_ack,
  input  logic                app_zq_ack,
  input  logic                init_calib_complete
);

  localparam int unsigned       LANES = DWIDTH / 32;
  localparam int unsigned       CW    = 33;  // beat counters must reach 2^32
  localparam logic [CW-1:0]     NB    = CW'(NBEATS);
  localparam int unsigned       OW    = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0]     MAXO  = OW'(MAX_OUTST);
  localparam logic [AWIDTH-1:0] BASE  = AWIDTH'(BASE_ADDR);
  localparam logic [AWIDTH-1:0] STEP  = AWIDTH'(ADDR_STEP);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CAL, S_WR, S_RD, S_DONE} state_e;

  // Beat-k pattern: 32-bit lane j carries SEED ^ k ^ j.
  function automatic logic [DWIDTH-1:0] pattern(input logic [31:0] k);
    logic [DWIDTH-1:0] p;
    p = '0;
    for (int j = 0; j < int'(LANES); j++) p[j*32 +: 32] = SEED ^ k ^ 32'(j);
    return p;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              cmd_en_q, cmd_en_d;
  logic [AWIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [CW-1:0]     cmd_cnt_q, cmd_cnt_d;
  logic              wren_q, wren_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     dat_cnt_q, dat_cnt_d;
  logic [OW-1:0]     out_q, out_d;
  logic [CW-1:0]     rcv_cnt_q, rcv_cnt_d;

  logic cmd_hs, dat_hs, rd_issue, rd_ret, enter_wr, enter_rd;

  // Status inputs the generator has no use for.
  logic unused_inputs;
  assign unused_inputs = ^{app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision; WR exits only once both channels have finished.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_WAIT_CAL;
      S_WAIT_CAL: if (init_calib_complete) state_d = (mode_q == 2'b10) ? S_RD : S_WR;
      S_WR:       if (cmd_cnt_q == NB && dat_cnt_q == NB)
                    state_d = (mode_q == 2'b01) ? S_DONE : S_RD;
      S_RD:       if (rcv_cnt_q == NB) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    busy    = state_q inside {S_WAIT_CAL, S_WR, S_RD};
    app_cmd = (state_q == S_RD) ? 3'b001 : 3'b000;
  end

  // Command, write-data and read-check datapath next values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mode_d     = mode_q;
    done_d     = done_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    cmd_en_d   = cmd_en_q;
    cmd_addr_d = cmd_addr_q;
    cmd_cnt_d  = cmd_cnt_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    dat_cnt_d  = dat_cnt_q;
    out_d      = out_q;
    rcv_cnt_d  = rcv_cnt_q;

    cmd_hs   = cmd_en_q & app_rdy;
    dat_hs   = wren_q & app_wdf_rdy;
    rd_issue = cmd_hs & (state_q == S_RD);
    rd_ret   = app_rd_data_valid & (state_q == S_RD);
    enter_wr = (state_q != S_WR) && (state_d == S_WR);
    enter_rd = (state_q != S_RD) && (state_d == S_RD);

    // A new pass clears the previous result.
    if (state_q == S_IDLE && start) begin
      mode_d    = mode;
      done_d    = 1'b0;
      error_d   = 1'b0;
      err_cnt_d = '0;
    end
    if (state_d == S_DONE) done_d = 1'b1;

    // Command channel: one pointer reused for the write then the read phase.
    if (enter_wr || enter_rd) begin
      cmd_cnt_d  = '0;
      cmd_addr_d = BASE;
      cmd_en_d   = 1'b0;
    end else if (cmd_hs) begin
      cmd_cnt_d  = cmd_cnt_q + 1'b1;
      cmd_addr_d = cmd_addr_q + STEP;
      cmd_en_d   = 1'b0;
    end

    // Returns and issues in the same cycle cancel out.
    out_d = enter_rd ? '0 : out_q + OW'(rd_issue) - OW'(rd_ret);

    // A held command stays up regardless of calibration; a new one needs it.
    if (!cmd_en_d && init_calib_complete && cmd_cnt_d < NB &&
        (state_d == S_WR || (state_d == S_RD && out_d < MAXO)))
      cmd_en_d = 1'b1;

    // Write-data channel advances independently of the command channel.
    if (enter_wr) begin
      dat_cnt_d = '0;
      wdata_d   = pattern(32'd0);
      wren_d    = 1'b0;
    end else if (dat_hs) begin
      dat_cnt_d = dat_cnt_q + 1'b1;
      wdata_d   = pattern(dat_cnt_d[31:0]);
      wren_d    = 1'b0;
    end
    if (!wren_d && init_calib_complete && state_d == S_WR && dat_cnt_d < NB)
      wren_d = 1'b1;

    // Read data returns in order; beat r is compared against P(r).
    if (enter_rd) rcv_cnt_d = '0;
    if (rd_ret) begin
      rcv_cnt_d = rcv_cnt_q + 1'b1;
      if (app_rd_data != pattern(rcv_cnt_q[31:0])) begin
        error_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  // Datapath registers; reset aborts any pass and drops every request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      cmd_en_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_cnt_q  <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      dat_cnt_q  <= '0;
      out_q      <= '0;
      rcv_cnt_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
      cmd_en_q   <= cmd_en_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      wren_q     <= wren_d;
      wdata_q    <= wdata_d;
      dat_cnt_q  <= dat_cnt_d;
      out_q      <= out_d;
      rcv_cnt_q  <= rcv_cnt_d;
    end
  end

  assign done         = done_q;
  assign error        = error_q;
  assign err_count    = err_cnt_q;
  assign app_en       = cmd_en_q;
  assign app_addr     = cmd_addr_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = '0;
  assign app_sr_req   = 1'b0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;

endmodule

// File: tb/tb_mig7_traffic_gen.sv
// tb_mig7_traffic_gen: drives mig7_traffic_gen against a behavioural MIG model
// with random ready/latency and checks every beat against the pattern rules.
`timescale 1ns/1ps
module tb_mig7_traffic_gen;

  localparam int          DW   = 64;
  localparam int          AW   = 12;
  localparam int          BASE = 12'hFD0;  // pass crosses the top of the address space
  localparam int          STEP = 8;
  localparam int          NB   = 12;
  localparam int          MAXO = 4;
  localparam logic [31:0] SEED = 32'hA5C3_1E0F;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] mode;
  logic busy, done, error;
  logic [15:0] err_count;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en;
  logic [DW-1:0] app_wdf_data;
  logic app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic app_wdf_wren;
  logic [DW-1:0] app_rd_data;
  logic app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy;
  logic app_sr_req, app_ref_req, app_zq_req;
  logic app_sr_active, app_ref_ack, app_zq_ack;
  logic init_calib_complete;

  mig7_traffic_gen #(
    .DWIDTH(DW), .AWIDTH(AW), .BASE_ADDR(BASE), .ADDR_STEP(STEP),
    .NBEATS(NB), .MAX_OUTST(MAXO), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
    .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy), .app_sr_req(app_sr_req),
    .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
    .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack),
    .app_zq_ack(app_zq_ack), .init_calib_complete(init_calib_complete)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules: two 32-bit lanes, lane j = SEED ^ k ^ j.
  function automatic logic [DW-1:0] exp_pat(input int unsigned k);
    return {SEED ^ k ^ 32'd1, SEED ^ k ^ 32'd0};
  endfunction

  function automatic int unsigned exp_addr(input int k);
    return (BASE + k * STEP) % (1 << AW);
  endfunction

  // Model state.
  int cyc = 0;
  int rdy_pol = 0;        // 0 always ready, 1 random, 2 never ready
  int rd_lat = 3;
  int corrupt_idx = -1;
  int wc_idx, wd_idx, rc_idx, rr_idx, outst, max_outst, exp_err;
  int unsigned   wcmd_q[$];
  logic [DW-1:0] wdat_q[$];
  int unsigned   pend_addr[$];
  int            pend_due[$];
  logic [DW-1:0] mem [int unsigned];

  // MIG model: decides ready/return at the falling edge for the next rising edge.
  task automatic mig_model();
    int unsigned a;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_addr.delete(); pend_due.delete();
        wcmd_q.delete(); wdat_q.delete();
        app_rd_data_valid = 1'b0;
        outst = 0;
      end else begin
        case (rdy_pol)
          0:       begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
          1:       begin app_rdy = 1'($urandom); app_wdf_rdy = 1'($urandom); end
          default: begin app_rdy = 1'b0; app_wdf_rdy = 1'b0; end
        endcase
        app_rd_data_valid = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          a = pend_addr.pop_front();
          void'(pend_due.pop_front());
          d = mem.exists(a) ? mem[a] : '0;
          if (rr_idx == corrupt_idx) d[5] = ~d[5];
          if (d != exp_pat(rr_idx)) exp_err++;
          app_rd_data = d;
          app_rd_data_valid = 1'b1;
          rr_idx++;
          outst--;
        end
        if (app_en) begin
          if (app_cmd == 3'b000) check("wr_addr", 64'(app_addr), 64'(exp_addr(wc_idx)));
          else                   check("rd_addr", 64'(app_addr), 64'(exp_addr(rc_idx)));
          if (app_rdy) begin
            if (app_cmd == 3'b000) begin
              wcmd_q.push_back(app_addr);
              wc_idx++;
            end else begin
              check("rd_cmd", 64'(app_cmd), 64'd1);
              pend_addr.push_back(app_addr);
              pend_due.push_back(cyc + rd_lat);
              rc_idx++;
              outst++;
              if (outst > max_outst) max_outst = outst;
            end
          end
        end
        if (app_wdf_wren) begin
          check("wr_data", 64'(app_wdf_data), 64'(exp_pat(wd_idx)));
          check("wdf_end", 64'(app_wdf_end), 64'd1);
          if (app_wdf_rdy) begin
            wdat_q.push_back(app_wdf_data);
            wd_idx++;
          end
        end
        while (wcmd_q.size() > 0 && wdat_q.size() > 0) mem[wcmd_q.pop_front()] = wdat_q.pop_front();
      end
    end
  endtask

  task automatic begin_pass(input logic [1:0] m);
    wc_idx = 0; wd_idx = 0; rc_idx = 0; rr_idx = 0; max_outst = 0; exp_err = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom);  // mode must be latched at start
  endtask

  task automatic finish_pass(input string tag, input logic [1:0] m);
    int n;
    int exp_w;
    int exp_r;
    n = 0;
    exp_w = (m == 2'b10) ? 0 : NB;
    exp_r = (m == 2'b01) ? 0 : NB;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"},    64'(done), 64'd1);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_errcnt"},  64'(err_count), 64'(exp_err));
    check({tag, "_error"},   64'(error), 64'(exp_err != 0));
    check({tag, "_nwcmd"},   64'(wc_idx), 64'(exp_w));
    check({tag, "_nwdat"},   64'(wd_idx), 64'(exp_w));
    check({tag, "_nrcmd"},   64'(rc_idx), 64'(exp_r));
    check({tag, "_nrcv"},    64'(rr_idx), 64'(exp_r));
    check({tag, "_outst_ok"}, 64'(max_outst <= MAXO), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_errcnt"}, 64'(err_count), 64'd0);
    check({tag, "_en"},    64'(app_en), 64'd0);
    check({tag, "_wren"},  64'(app_wdf_wren), 64'd0);
    check({tag, "_addr"},  64'(app_addr), 64'd0);
    check({tag, "_cmd"},   64'(app_cmd), 64'd0);
    check({tag, "_wdata"}, 64'(app_wdf_data), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 2'b00;
    app_rd_data = '0; app_rd_data_end = 1'b0; app_rd_data_valid = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_sr_active = 1'b0; app_ref_ack = 1'b0; app_zq_ack = 1'b0;
    init_calib_complete = 1'b1;
    fork
      mig_model();
    join_none

    // Reset state.
    #1;
    check_idle_outputs("reset");
    check("reset_mask", 64'(app_wdf_mask), 64'd0);
    check("reset_req", 64'({app_sr_req, app_ref_req, app_zq_req}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Always-ready write+read pass with first-command latency.
    rdy_pol = 0; rd_lat = 3;
    begin_pass(2'b00);
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_en_early", 64'(app_en), 64'd0);
    @(negedge clk);
    check("lat_en", 64'(app_en), 64'd1);
    check("lat_wren", 64'(app_wdf_wren), 64'd1);
    finish_pass("basic", 2'b00);
    repeat (5) @(negedge clk);
    check("done_held", 64'(done), 64'd1);

    // Random ready back-pressure, calibration low at start.
    rdy_pol = 1;
    for (int p = 0; p < 3; p++) begin
      rd_lat = $urandom_range(1, 20);
      init_calib_complete = 1'b0;
      begin_pass(2'b00);
      check("done_cleared", 64'(done), 64'd0);
      repeat (6) @(negedge clk);
      check("wait_cal_en", 64'(app_en), 64'd0);
      check("wait_cal_busy", 64'(busy), 64'd1);
      init_calib_complete = 1'b1;
      finish_pass("random", 2'b00);
    end

    // Corrupted beat 2, then a clean pass clears the result.
    rdy_pol = 0; rd_lat = 5; corrupt_idx = 2;
    begin_pass(2'b00);
    finish_pass("corrupt", 2'b00);
    check("corrupt_errcnt", 64'(err_count), 64'd1);
    check("corrupt_error", 64'(error), 64'd1);
    corrupt_idx = -1;
    begin_pass(2'b00);
    finish_pass("clean", 2'b00);
    check("clean_error", 64'(error), 64'd0);

    // Long latency limits outstanding reads.
    rd_lat = 100;
    begin_pass(2'b10);
    finish_pass("lat100", 2'b10);
    check("lat100_max_outst", 64'(max_outst), 64'(MAXO));

    // Write-only, read-only, mode 11, then read of an unwritten memory.
    rdy_pol = 1; rd_lat = 7;
    begin_pass(2'b01);
    finish_pass("wronly", 2'b01);
    begin_pass(2'b10);
    finish_pass("rdonly", 2'b10);
    begin_pass(2'b11);
    finish_pass("mode11", 2'b00);
    mem.delete();
    begin_pass(2'b10);
    finish_pass("unwritten", 2'b10);
    check("unwritten_errcnt", 64'(err_count), 64'(NB));

    // Reset during RD is asynchronous.
    rdy_pol = 0; rd_lat = 10;
    begin_pass(2'b00);
    n = 0;
    while (rc_idx < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_rd", 64'(rc_idx >= 3), 64'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("after_rst_busy", 64'(busy), 64'd0);

    // start while busy is ignored.
    begin_pass(2'b01);
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    finish_pass("start_busy", 2'b01);

    // Calibration drop in WR keeps held requests and issues nothing new.
    rdy_pol = 2;
    begin_pass(2'b00);
    n = 0;
    while (app_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    init_calib_complete = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cal_hold_en", 64'(app_en), 64'd1);
      check("cal_hold_wren", 64'(app_wdf_wren), 64'd1);
    end
    rdy_pol = 0;
    repeat (6) @(negedge clk);
    check("cal_drop_nwcmd", 64'(wc_idx), 64'd1);
    check("cal_drop_nwdat", 64'(wd_idx), 64'd1);
    check("cal_drop_en", 64'(app_en), 64'd0);
    check("cal_drop_wren", 64'(app_wdf_wren), 64'd0);
    init_calib_complete = 1'b1;
    finish_pass("cal_drop", 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
